// File: rtl/mul_share_arbiter.sv
// Round-robin share of one signed x unsigned multiplier among N requesters.
// Two registered stages (operand, product) with full valid/ready backpressure.
module mul_share_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ID_W   = 2,
    parameter int DIN0_W = 22,
    parameter int DIN1_W = 14,
    parameter int DOUT_W = 36
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*DIN0_W-1:0]    req_a,
    input  logic [N_REQ*DIN1_W-1:0]    req_b,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [DOUT_W-1:0]          res_data,
    output logic [ID_W-1:0]            res_id,
    output logic                       busy
);

    typedef struct packed {
        logic [DIN0_W-1:0] a;
        logic [DIN1_W-1:0] b;
        logic [ID_W-1:0]   id;
    } s1_t;

    logic [ID_W-1:0]          ptr;
    logic [ID_W-1:0]          g;
    logic [ID_W-1:0]          idx;
    logic                     found;
    logic                     v1;
    s1_t                      s1;
    s1_t                      s1_nxt;
    logic                     adv1;
    logic                     adv2;
    logic                     accept;
    logic signed [DOUT_W-1:0] ax;
    logic signed [DOUT_W-1:0] bx;
    logic signed [DOUT_W-1:0] prod;

    // First valid requester at or after ptr, wrapping on the ID width.
    always_comb begin
        found = 1'b0;
        g     = '0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = ptr + ID_W'(k);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                g     = idx;
            end
        end
    end

    assign adv2   = !res_valid || res_ready;
    assign adv1   = !v1 || adv2;
    assign accept = found && adv1;
    assign busy   = v1 || res_valid;

    always_comb begin
        req_ready = '0;
        if (accept && ap_rst_n)
            req_ready[g] = 1'b1;
    end

    always_comb begin
        s1_nxt.a  = req_a[int'(g)*DIN0_W +: DIN0_W];
        s1_nxt.b  = req_b[int'(g)*DIN1_W +: DIN1_W];
        s1_nxt.id = g;
    end

    // Operands widened to the product width; the exact result always fits.
    assign ax   = DOUT_W'($signed(s1.a));
    assign bx   = DOUT_W'($signed({1'b0, s1.b}));
    assign prod = ax * bx;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= g + 1'b1;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            v1 <= 1'b0;
            s1 <= '0;
        end else if (adv1) begin
            v1 <= accept;
            if (accept)
                s1 <= s1_nxt;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
        end else if (adv2) begin
            res_valid <= v1;
            if (v1) begin
                res_data <= prod;
                res_id   <= s1.id;
            end
        end
    end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed checks for mul_share_arbiter: vector table plus
// round-robin, backpressure, fairness and mid-stream reset sequences.
module tb_mul_share_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int AW = 22;
    localparam int BW = 14;
    localparam int DW = 36;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_a;
    logic [N*BW-1:0] req_b;
    logic            res_valid;
    logic            res_ready;
    logic [DW-1:0]   res_data;
    logic [IW-1:0]   res_id;
    logic            busy;

    int checks = 0;
    int errors = 0;

    mul_share_arbiter dut (
        .ap_clk    (clk),
        .ap_rst_n  (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     id;
        longint a;
        longint b;
        longint p;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] ed;
        logic [DW-1:0] held_d;
        logic [IW-1:0] held_id;
        int            acc;
        int            others;
        bit            got0;

        vt[0] = '{2, -5, 3, -15};
        vt[1] = '{0, -2097152, 16383, -64'sd34357641216};
        vt[2] = '{1, 2097151, 16383, 64'sd34357624833};
        vt[3] = '{3, 0, 16383, 0};
        vt[4] = '{0, 1, 0, 0};
        vt[5] = '{3, -1, 16383, -16383};
        vt[6] = '{1, 1000, 1000, 1000000};
        vt[7] = '{2, -1000, 12345, -12345000};

        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;
        #12;
        chk("rst_res_valid", 64'(res_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_res_data", 64'(res_data), 64'(0));
        chk("rst_res_id", 64'(res_id), 64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            req_a = '0;
            req_b = '0;
            req_a[vt[i].id*AW +: AW] = AW'(vt[i].a);
            req_b[vt[i].id*BW +: BW] = BW'(vt[i].b);
            req_valid = N'(1) << vt[i].id;
            ed = DW'(vt[i].p);
            #1;
            chk("vec_ready", 64'(req_ready), 64'(N'(1) << vt[i].id));
            tick();
            req_valid = '0;
            chk("vec_not_early", 64'(res_valid), 64'(0));
            chk("vec_busy", 64'(busy), 64'(1));
            tick();
            chk("vec_valid", 64'(res_valid), 64'(1));
            chk("vec_data", 64'(res_data), 64'(ed));
            chk("vec_id", 64'(res_id), 64'(vt[i].id));
            tick();
            chk("vec_idle", 64'(busy), 64'(0));
        end

        // Round robin with every requester valid.
        do_reset();
        for (int i = 0; i < N; i++) begin
            req_a[i*AW +: AW] = AW'(i + 1);
            req_b[i*BW +: BW] = BW'(1);
        end
        req_valid = '1;
        res_ready = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) begin
            chk("rr_grant", 64'(req_ready), 64'(N'(1) << (k % N)));
            if (k >= 2) begin
                chk("rr_valid", 64'(res_valid), 64'(1));
                chk("rr_id", 64'(res_id), 64'((k - 2) % N));
                chk("rr_data", 64'(res_data), 64'(((k - 2) % N) + 1));
            end
            tick();
        end
        req_valid = '0;
        tick();
        tick();

        // Backpressure: two requesters, output stalled for five cycles.
        do_reset();
        req_a = '0;
        req_b = '0;
        req_a[0*AW +: AW] = AW'(10);
        req_a[1*AW +: AW] = AW'(20);
        req_b[0*BW +: BW] = BW'(2);
        req_b[1*BW +: BW] = BW'(2);
        req_valid = 4'b0011;
        res_ready = 1'b0;
        acc = 0;
        for (int k = 0; k < 5; k++) begin
            #1;
            if ((req_valid & req_ready) != '0)
                acc++;
            if (k >= 2) begin
                chk("bp_held_valid", 64'(res_valid), 64'(1));
                chk("bp_held_data", 64'(res_data), 64'(20));
                chk("bp_held_id", 64'(res_id), 64'(0));
            end
            tick();
        end
        chk("bp_accepts", 64'(acc), 64'(2));
        req_valid = '0;
        res_ready = 1'b1;
        #1;
        chk("bp_out0_data", 64'(res_data), 64'(20));
        chk("bp_out0_id", 64'(res_id), 64'(0));
        tick();
        chk("bp_out1_valid", 64'(res_valid), 64'(1));
        chk("bp_out1_data", 64'(res_data), 64'(40));
        chk("bp_out1_id", 64'(res_id), 64'(1));
        tick();
        chk("bp_drained", 64'(busy), 64'(0));

        // Fairness: 1 and 3 contend, 0 joins at cycle 10.
        do_reset();
        req_valid = 4'b1010;
        res_ready = 1'b1;
        #1;
        for (int c = 0; c < 10; c++) begin
            chk("fair_alt", 64'(req_ready), 64'((c % 2 == 0) ? 4'b0010 : 4'b1000));
            tick();
        end
        req_valid = 4'b1011;
        #1;
        others = 0;
        got0 = 1'b0;
        for (int c = 0; c < 4 && !got0; c++) begin
            if (req_ready[0])
                got0 = 1'b1;
            else if (req_ready != '0)
                others++;
            tick();
        end
        chk("fair_got0", 64'(got0), 64'(1));
        chk("fair_wait_le2", 64'(others <= 2), 64'(1));
        req_valid = '0;
        tick();
        tick();

        // Reset with both stages full.
        do_reset();
        req_valid = 4'b0110;
        res_ready = 1'b0;
        tick();
        tick();
        chk("mr_full_busy", 64'(busy), 64'(1));
        chk("mr_full_valid", 64'(res_valid), 64'(1));
        held_d  = res_data;
        held_id = res_id;
        chk("mr_full_id", 64'(held_id), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_valid", 64'(res_valid), 64'(0));
        chk("mr_busy", 64'(busy), 64'(0));
        chk("mr_ready", 64'(req_ready), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        res_ready = 1'b1;
        #1;
        chk("mr_first_grant", 64'(req_ready), 64'(4'b0010));
        tick();
        req_valid = '0;
        tick();
        chk("mr_first_id", 64'(res_id), 64'(1));
        chk("mr_first_valid", 64'(res_valid), 64'(1));
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
